// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core.
// Moore decode of datapath controls; only pc_write also depends on the ALU zero flag.
module multi_cycle_ctrl #(
    parameter int unsigned STATE_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       illegal
);

    localparam logic [STATE_W-1:0] FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] EXECUTER = STATE_W'(6);
    localparam logic [STATE_W-1:0] EXECUTEI = STATE_W'(7);
    localparam logic [STATE_W-1:0] ALUWB    = STATE_W'(8);
    localparam logic [STATE_W-1:0] JALR     = STATE_W'(9);
    localparam logic [STATE_W-1:0] JAL      = STATE_W'(10);
    localparam logic [STATE_W-1:0] BEQ      = STATE_W'(11);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               pc_update;
    logic               branch;

    // State register; reset lands in FETCH so the fetch decode is visible while held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; unreachable encodings fall back to FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECUTER;
                    OP_ITYPE:          state_d = EXECUTEI;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_BEQ:            state_d = BEQ;
                    default:           state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            JALR:     state_d = JAL;
            JAL:      state_d = ALUWB;
            BEQ:      state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // Per-state output decode; everything defaults to 0.
    always_comb begin
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            DECODE: begin
                // Branch/jal target is formed here regardless of opcode.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
                    OP_JAL, OP_JALR, OP_BEQ: illegal = 1'b0;
                    default:                 illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD: begin
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_write = 1'b1;
            end
            JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            JAL: begin
                // PC takes the target in ALUOut while the ALU forms the link value.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // The only Mealy term: a taken branch depends on the live zero flag.
    always_comb begin
        pc_write = pc_update | (branch & zero);
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks instructions cycle by cycle and
// checks the full control vector against hand-built per-state constants.
module tb_multi_cycle_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       illegal;

    int tests;
    int fails;

    // Vector order: pc_write adr_src mem_write ir_write result_src alu_src_a alu_src_b alu_op
    //               reg_write illegal
    localparam logic [13:0] V_FETCH    = 14'b1_0_0_1_10_00_10_00_0_0;
    localparam logic [13:0] V_DECODE   = 14'b0_0_0_0_00_01_01_00_0_0;
    localparam logic [13:0] V_DEC_ILL  = 14'b0_0_0_0_00_01_01_00_0_1;
    localparam logic [13:0] V_MEMADR   = 14'b0_0_0_0_00_10_01_00_0_0;
    localparam logic [13:0] V_MEMREAD  = 14'b0_1_0_0_00_00_00_00_0_0;
    localparam logic [13:0] V_MEMWB    = 14'b0_0_0_0_01_00_00_00_1_0;
    localparam logic [13:0] V_MEMWRITE = 14'b0_1_1_0_00_00_00_00_0_0;
    localparam logic [13:0] V_EXECR    = 14'b0_0_0_0_00_10_00_10_0_0;
    localparam logic [13:0] V_EXECI    = 14'b0_0_0_0_00_10_01_10_0_0;
    localparam logic [13:0] V_ALUWB    = 14'b0_0_0_0_00_00_00_00_1_0;
    localparam logic [13:0] V_JALR     = 14'b0_0_0_0_00_10_01_00_0_0;
    localparam logic [13:0] V_JAL      = 14'b1_0_0_0_00_01_10_00_0_0;
    localparam logic [13:0] V_BEQ_T    = 14'b1_0_0_0_00_10_00_01_0_0;
    localparam logic [13:0] V_BEQ_NT   = 14'b0_0_0_0_00_10_00_01_0_0;

    logic [13:0] obs;
    assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                  alu_op, reg_write, illegal};

    multi_cycle_ctrl #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .zero       (zero),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [13:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling happens on the falling edge.
    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        op    = 7'b0000000;
        zero  = 1'b0;
        nxt();
        nxt();
        chk("reset_fetch", V_FETCH);
        rst = 1'b0;

        // Unsupported opcode: FETCH, DECODE(illegal), back to FETCH
        nxt(); chk("ill_decode", V_DEC_ILL);
        nxt(); chk("ill_fetch", V_FETCH);

        // lw, interrupted by reset in MEMREAD
        op = 7'b0000011;
        nxt(); chk("lw_decode", V_DECODE);
        nxt(); chk("lw_memadr", V_MEMADR);
        nxt(); chk("lw_memread", V_MEMREAD);
        rst = 1'b1;
        #1 chk("rst_mid_memread", V_FETCH);
        nxt(); chk("rst_held", V_FETCH);
        rst = 1'b0;
        nxt(); chk("rst_release_decode", V_DECODE);

        // full lw
        nxt(); chk("lw2_memadr", V_MEMADR);
        nxt(); chk("lw2_memread", V_MEMREAD);
        nxt(); chk("lw2_memwb", V_MEMWB);
        nxt(); chk("lw2_fetch", V_FETCH);

        // sw
        op = 7'b0100011;
        nxt(); chk("sw_decode", V_DECODE);
        nxt(); chk("sw_memadr", V_MEMADR);
        nxt(); chk("sw_memwrite", V_MEMWRITE);
        nxt(); chk("sw_fetch", V_FETCH);

        // beq taken, with zero toggled in FETCH and DECODE
        op   = 7'b1100011;
        zero = 1'b1;
        #1 chk("beq_fetch_zero1", V_FETCH);
        nxt(); chk("beq_decode_zero1", V_DECODE);
        nxt(); chk("beq_taken", V_BEQ_T);
        zero = 1'b0;
        #1 chk("beq_zero_drop", V_BEQ_NT);
        nxt(); chk("beq_fetch", V_FETCH);

        // beq not taken
        nxt(); chk("beq2_decode", V_DECODE);
        nxt(); chk("beq_not_taken", V_BEQ_NT);
        nxt(); chk("beq2_fetch", V_FETCH);

        // jalr
        op = 7'b1100111;
        nxt(); chk("jalr_decode", V_DECODE);
        nxt(); chk("jalr_jalr", V_JALR);
        nxt(); chk("jalr_jal", V_JAL);
        nxt(); chk("jalr_aluwb", V_ALUWB);
        nxt(); chk("jalr_fetch", V_FETCH);

        // jal
        op = 7'b1101111;
        nxt(); chk("jal_decode", V_DECODE);
        nxt(); chk("jal_jal", V_JAL);
        nxt(); chk("jal_aluwb", V_ALUWB);
        nxt(); chk("jal_fetch", V_FETCH);

        // R-type
        op = 7'b0110011;
        nxt(); chk("r_decode", V_DECODE);
        nxt(); chk("r_exec", V_EXECR);
        nxt(); chk("r_aluwb", V_ALUWB);
        nxt(); chk("r_fetch", V_FETCH);

        // I-type
        op = 7'b0010011;
        nxt(); chk("i_decode", V_DECODE);
        nxt(); chk("i_exec", V_EXECI);
        nxt(); chk("i_aluwb", V_ALUWB);
        nxt(); chk("i_fetch", V_FETCH);

        // another unsupported opcode
        op = 7'b1111111;
        nxt(); chk("ill2_decode", V_DEC_ILL);
        nxt(); chk("ill2_fetch", V_FETCH);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
